// File: rtl/adc_scan_ctrl_if.sv
// Signal bundle between adc_scan_ctrl (slave) and its configuration/sequencer side (master).
// START/STOP are one-cycle requests sampled on the clock edge; SEQ_START is a one-cycle trigger and SEQ_DONE is a level the sequencer raises once per conversion.
interface adc_scan_ctrl_if #(
    parameter int SCAN_CNT_BITS = 16,
    parameter int PERIOD_BITS   = 16
);
    logic                     START;
    logic                     STOP;
    logic [7:0]               CHAN_MASK;
    logic [SCAN_CNT_BITS-1:0] NUM_SCANS;
    logic [7:0]               SETTLE;
    logic [PERIOD_BITS-1:0]   PERIOD;
    logic                     SEQ_DONE;
    logic [2:0]               SEL;
    logic                     SEQ_START;
    logic                     BUSY;
    logic                     DONE;
    logic [SCAN_CNT_BITS-1:0] SCAN_CNT;
    logic                     OVERRUN;
    logic                     TIMEOUT_ERR;
    logic [2:0]               state_dbg;

    modport master (
        output START, STOP, CHAN_MASK, NUM_SCANS, SETTLE, PERIOD, SEQ_DONE,
        input  SEL, SEQ_START, BUSY, DONE, SCAN_CNT, OVERRUN, TIMEOUT_ERR, state_dbg
    );

    modport slave (
        input  START, STOP, CHAN_MASK, NUM_SCANS, SETTLE, PERIOD, SEQ_DONE,
        output SEL, SEQ_START, BUSY, DONE, SCAN_CNT, OVERRUN, TIMEOUT_ERR, state_dbg
    );
endinterface

// File: rtl/adc_scan_ctrl.sv
// ADC01 conversion scheduler: steps SEL through a channel mask, triggers and paces conversions, counts scans.
// Optional SEQ_DONE watchdog compiled in with ADC_SCAN_TIMEOUT_EN; otherwise TIMEOUT_ERR stays 0.
module adc_scan_ctrl #(
    parameter int SCAN_CNT_BITS = 16,
    parameter int PERIOD_BITS   = 16,
    parameter int TIMEOUT       = 65535
) (
    input  logic           BUS_CLK,
    input  logic           BUS_RST,
    adc_scan_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_SETTLE, S_TRIG, S_WAIT_DONE, S_PACE
    } state_e;

    localparam int CW      = ((PERIOD_BITS > 8) ? PERIOD_BITS : 8) + 2;
    localparam int WD_BITS = $clog2(TIMEOUT + 1);
`ifdef ADC_SCAN_TIMEOUT_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    state_e                   state_q, state_d;
    logic [7:0]               mask_q, mask_d;
    logic [SCAN_CNT_BITS-1:0] num_q, num_d;
    logic [7:0]               settle_q, settle_d;
    logic [PERIOD_BITS-1:0]   period_q, period_d;
    logic [3:0]               ptr_q, ptr_d;
    logic [7:0]               settle_cnt_q, settle_cnt_d;
    logic [PERIOD_BITS-1:0]   per_cnt_q, per_cnt_d;
    logic [WD_BITS-1:0]       wd_q, wd_d;
    logic                     stop_pend_q, stop_pend_d;
    logic [2:0]               sel_q, sel_d;
    logic                     seq_start_q, seq_start_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [SCAN_CNT_BITS-1:0] scan_cnt_q, scan_cnt_d;
    logic                     overrun_q, overrun_d;
    logic                     timeout_err_q, timeout_err_d;

    logic [2:0]               next_ch;
    logic                     more_ch;
    logic [PERIOD_BITS-1:0]   per_inc;
    logic                     pace_ok;

    // Lowest enabled channel at or above the pointer.
    always_comb begin
        next_ch = '0;
        more_ch = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i] && (4'(i) >= ptr_q)) begin
                next_ch = 3'(i);
                more_ch = 1'b1;
            end
        end
    end

    assign per_inc = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + PERIOD_BITS'(1);
    // Release pacing early by the SELECT + SETTLE + TRIG overhead so trigger spacing equals PERIOD.
    assign pace_ok = (CW'(per_cnt_q) + CW'(settle_q) + CW'(2)) >= CW'(period_q);

    always_comb begin
        state_d       = state_q;
        mask_d        = mask_q;
        num_d         = num_q;
        settle_d      = settle_q;
        period_d      = period_q;
        ptr_d         = ptr_q;
        settle_cnt_d  = settle_cnt_q;
        per_cnt_d     = per_cnt_q;
        wd_d          = wd_q;
        stop_pend_d   = stop_pend_q;
        sel_d         = sel_q;
        done_d        = 1'b0;
        scan_cnt_d    = scan_cnt_q;
        overrun_d     = overrun_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.START && (bus.CHAN_MASK != 8'd0)) begin
                    mask_d        = bus.CHAN_MASK;
                    num_d         = bus.NUM_SCANS;
                    settle_d      = bus.SETTLE;
                    period_d      = bus.PERIOD;
                    scan_cnt_d    = '0;
                    overrun_d     = 1'b0;
                    timeout_err_d = 1'b0;
                    ptr_d         = '0;
                    state_d       = S_SELECT;
                end
            end
            S_SELECT: begin
                if (bus.STOP) begin
                    state_d = S_IDLE;
                end else begin
                    sel_d        = next_ch;
                    ptr_d        = {1'b0, next_ch} + 4'd1;
                    settle_cnt_d = 8'd1;
                    state_d      = (settle_q == 8'd0) ? S_TRIG : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (bus.STOP) begin
                    state_d = S_IDLE;
                end else if (settle_cnt_q == settle_q) begin
                    state_d = S_TRIG;
                end else begin
                    settle_cnt_d = settle_cnt_q + 8'd1;
                end
            end
            S_TRIG: begin
                per_cnt_d = PERIOD_BITS'(1);
                wd_d      = WD_BITS'(1);
                if (bus.STOP) stop_pend_d = 1'b1;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                per_cnt_d = per_inc;
                if (wd_q < WD_BITS'(TIMEOUT)) wd_d = wd_q + WD_BITS'(1);
                if (bus.STOP) stop_pend_d = 1'b1;
                if (bus.SEQ_DONE) begin
                    if (per_cnt_q > period_q) overrun_d = 1'b1;
                    state_d = (stop_pend_q || bus.STOP) ? S_IDLE : S_PACE;
                end else if (WD_EN && (wd_q >= WD_BITS'(TIMEOUT))) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            S_PACE: begin
                per_cnt_d = per_inc;
                if (bus.STOP) begin
                    state_d = S_IDLE;
                end else if (pace_ok) begin
                    if (more_ch) begin
                        state_d = S_SELECT;
                    end else begin
                        scan_cnt_d = scan_cnt_q + SCAN_CNT_BITS'(1);
                        ptr_d      = '0;
                        if ((num_q != '0) && (scan_cnt_d == num_q)) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_SELECT;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_IDLE) stop_pend_d = 1'b0;
        // Outputs are registered from the next state so they line up with the state they describe.
        seq_start_d = (state_d == S_TRIG);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            state_q       <= S_IDLE;
            mask_q        <= '0;
            num_q         <= '0;
            settle_q      <= '0;
            period_q      <= '0;
            ptr_q         <= '0;
            settle_cnt_q  <= '0;
            per_cnt_q     <= '0;
            wd_q          <= '0;
            stop_pend_q   <= 1'b0;
            sel_q         <= '0;
            seq_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            scan_cnt_q    <= '0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            num_q         <= num_d;
            settle_q      <= settle_d;
            period_q      <= period_d;
            ptr_q         <= ptr_d;
            settle_cnt_q  <= settle_cnt_d;
            per_cnt_q     <= per_cnt_d;
            wd_q          <= wd_d;
            stop_pend_q   <= stop_pend_d;
            sel_q         <= sel_d;
            seq_start_q   <= seq_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            scan_cnt_q    <= scan_cnt_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.SEL         = sel_q;
    assign bus.SEQ_START   = seq_start_q;
    assign bus.BUSY        = busy_q;
    assign bus.DONE        = done_q;
    assign bus.SCAN_CNT    = scan_cnt_q;
    assign bus.OVERRUN     = overrun_q;
    assign bus.TIMEOUT_ERR = timeout_err_q;
    assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Directed bench for adc_scan_ctrl: sequencer model answers each trigger after conv_len cycles.
module tb_adc_scan_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;

  adc_scan_ctrl_if #(.SCAN_CNT_BITS(16), .PERIOD_BITS(16)) bus();

  adc_scan_ctrl #(.SCAN_CNT_BITS(16), .PERIOD_BITS(16), .TIMEOUT(100)) dut (
    .BUS_CLK (clk),
    .BUS_RST (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int conv_len = 10;
  int done_at = -1;
  int n_starts = 0;
  int n_done = 0;
  int done_cyc = -1;
  int busy_fall_cyc = -1;
  int start_cyc = 0;
  logic busy_prev = 1'b0;
  int start_q[$];
  logic [2:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: sample outputs just after the edge, then drive the sequencer model for this cycle.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.SEQ_START) begin
      n_starts++;
      start_q.push_back(cyc);
      if (exp_q.size() > 0) check_eq("sel_at_trigger", 32'(bus.SEL), 32'(exp_q.pop_front()));
      if (conv_len > 0) done_at = cyc + conv_len;
    end
    if (bus.DONE) begin
      n_done++;
      done_cyc = cyc;
    end
    if (busy_prev && !bus.BUSY) busy_fall_cyc = cyc;
    busy_prev = bus.BUSY;
    bus.SEQ_DONE = (cyc == done_at);
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_logs();
    n_starts = 0;
    n_done = 0;
    done_cyc = -1;
    busy_fall_cyc = -1;
    done_at = -1;
    start_q.delete();
    exp_q.delete();
  endtask

  task automatic start_scan(input logic [7:0] mask, input int num, input int settle, input int period);
    bus.CHAN_MASK = mask;
    bus.NUM_SCANS = 16'(num);
    bus.SETTLE    = 8'(settle);
    bus.PERIOD    = 16'(period);
    bus.START     = 1'b1;
    start_cyc     = cyc;
    step();
    bus.START     = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.STOP = 1'b1;
    step();
    bus.STOP = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && bus.BUSY; i++) step();
    check_eq("wait_idle", 32'(bus.BUSY), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step_n(2);
    rst = 1'b0;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    bus.START = 1'b0;
    bus.STOP = 1'b0;
    bus.CHAN_MASK = '0;
    bus.NUM_SCANS = '0;
    bus.SETTLE = '0;
    bus.PERIOD = '0;
    bus.SEQ_DONE = 1'b0;

    // Reset values
    step_n(2);
    check_eq("rst_sel", 32'(bus.SEL), 0);
    check_eq("rst_seq_start", 32'(bus.SEQ_START), 0);
    check_eq("rst_busy", 32'(bus.BUSY), 0);
    check_eq("rst_done", 32'(bus.DONE), 0);
    check_eq("rst_scan_cnt", 32'(bus.SCAN_CNT), 0);
    check_eq("rst_overrun", 32'(bus.OVERRUN), 0);
    check_eq("rst_timeout_err", 32'(bus.TIMEOUT_ERR), 0);
    check_eq("rst_state", 32'(bus.state_dbg), 0);
    rst = 1'b0;
    step();

    // Two scans over channels 0,2,5 with settling, no pacing
    clear_logs();
    conv_len = 10;
    exp_q.push_back(3'd0); exp_q.push_back(3'd2); exp_q.push_back(3'd5);
    exp_q.push_back(3'd0); exp_q.push_back(3'd2); exp_q.push_back(3'd5);
    start_scan(8'b0010_0101, 2, 4, 0);
    check_eq("busy_at_cycle1", 32'(bus.BUSY), 1);
    wait_idle(500);
    check_eq("scan_n_starts", n_starts, 6);
    check_eq("scan_first_trig", start_q[0] - start_cyc, 6);
    check_eq("scan_spacing", start_q[1] - start_q[0], 17);
    check_eq("scan_cnt", 32'(bus.SCAN_CNT), 2);
    check_eq("scan_n_done", n_done, 1);
    check_eq("done_with_busy_fall", done_cyc, busy_fall_cyc);
    check_eq("done_latency", done_cyc - start_q[5], 12);
    check_eq("sel_holds_idle", 32'(bus.SEL), 5);

    // Pacing to PERIOD = 50 with short conversions
    clear_logs();
    conv_len = 10;
    start_scan(8'h03, 2, 0, 50);
    wait_idle(1000);
    check_eq("pace_n_starts", n_starts, 4);
    for (int i = 1; i < 4; i++) check_eq("pace_spacing", start_q[i] - start_q[i-1], 50);
    check_eq("pace_no_overrun", 32'(bus.OVERRUN), 0);

    // Conversion longer than PERIOD
    clear_logs();
    conv_len = 60;
    start_scan(8'h01, 2, 0, 50);
    wait_idle(1000);
    check_eq("ovr_spacing", start_q[1] - start_q[0], 63);
    check_eq("ovr_set", 32'(bus.OVERRUN), 1);
    step_n(5);
    check_eq("ovr_sticky", 32'(bus.OVERRUN), 1);

    // Continuous mode, STOP during WAIT_DONE
    clear_logs();
    conv_len = 10;
    start_scan(8'h01, 0, 0, 0);
    check_eq("ovr_cleared_by_start", 32'(bus.OVERRUN), 0);
    step_n(3);
    pulse_stop();
    step_n(6);
    check_eq("stop_busy_before_done", 32'(bus.BUSY), 1);
    wait_idle(100);
    check_eq("stop_idle_after_done", busy_fall_cyc - start_cyc, 13);
    check_eq("stop_state_idle", 32'(bus.state_dbg), 0);
    step_n(30);
    check_eq("stop_n_starts", n_starts, 1);
    check_eq("stop_no_done", n_done, 0);

    // START with empty mask is ignored
    clear_logs();
    start_scan(8'h00, 1, 0, 0);
    step_n(4);
    check_eq("mask0_busy", 32'(bus.BUSY), 0);
    check_eq("mask0_n_starts", n_starts, 0);

    // Second START while busy is ignored
    clear_logs();
    start_scan(8'h01, 1, 0, 0);
    step_n(3);
    bus.CHAN_MASK = 8'hFF;
    bus.NUM_SCANS = 16'd5;
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    wait_idle(500);
    check_eq("restart_n_starts", n_starts, 1);
    check_eq("restart_scan_cnt", 32'(bus.SCAN_CNT), 1);
    check_eq("restart_n_done", n_done, 1);

    // Reset during SETTLE, then a normal run from channel 0 of the mask
    clear_logs();
    start_scan(8'h06, 1, 8, 0);
    step_n(3);
    check_eq("pre_rst_sel", 32'(bus.SEL), 1);
    rst = 1'b1;
    #1;
    check_eq("async_rst_sel", 32'(bus.SEL), 0);
    check_eq("async_rst_busy", 32'(bus.BUSY), 0);
    check_eq("async_rst_state", 32'(bus.state_dbg), 0);
    step();
    rst = 1'b0;
    step();
    clear_logs();
    conv_len = 5;
    exp_q.push_back(3'd1); exp_q.push_back(3'd2);
    start_scan(8'h06, 1, 2, 0);
    wait_idle(300);
    check_eq("post_rst_n_starts", n_starts, 2);
    check_eq("post_rst_scan_cnt", 32'(bus.SCAN_CNT), 1);
    check_eq("post_rst_n_done", n_done, 1);

    // Sequencer never answers
    clear_logs();
    conv_len = 0;
    start_scan(8'h01, 1, 0, 0);
`ifdef ADC_SCAN_TIMEOUT_EN
    wait_idle(300);
    check_eq("wd_fall_cycle", busy_fall_cyc - start_cyc, 103);
    check_eq("wd_timeout_err", 32'(bus.TIMEOUT_ERR), 1);
    check_eq("wd_no_done", n_done, 0);
`else
    step_n(150);
    check_eq("nowd_still_busy", 32'(bus.BUSY), 1);
    check_eq("nowd_timeout_err", 32'(bus.TIMEOUT_ERR), 0);
`endif
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
